phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
Allocator for the 128-entry physical register file. It hands out free physical tags (pd) to the rename stage and takes back tags released at commit. It also snapshots allocation state at branch dispatch and restores it on mispredict, so squashed destinations return to the pool in one cycle. It sits between rename/dispatch and the ROB commit path, and owns every tag that the PRF write ports (ALU, branch, MEM) may target.

Parameters:
NUM_PREGS, 128, physical registers; tag width TAG_W = $clog2(NUM_PREGS) = 7
NUM_AREGS, 32, architectural registers; p0..p31 are the reset-time arch mapping and are never in the initial pool
NUM_CKPT, 4, branch checkpoint slots; CKPT_W = $clog2(NUM_CKPT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
alloc_req  in  1  rename requests one tag this cycle
alloc_valid  out  1  combinational; high when the pool is non-empty and alloc_pd is valid
alloc_pd  out  TAG_W  combinational; tag at the head of the pool
release_en  in  1  commit frees one tag
release_pd  in  TAG_W  tag being freed (old mapping of the committing rd)
ckpt_save_en  in  1  save allocation state into a slot
ckpt_save_id  in  CKPT_W  slot to write
recover_en  in  1  mispredict; restore a slot
recover_id  in  CKPT_W  slot to restore
free_count  out  TAG_W+1  registered count of free tags
empty  out  1  free_count == 0

Behaviour:
- Storage: circular buffer of NUM_PREGS entries x TAG_W. head_ptr and tail_ptr are TAG_W+1 bits wide; the MSB is the wrap bit. free_count = tail_ptr - head_ptr, modulo 2^(TAG_W+1).
- Reset (synchronous): entry i = NUM_AREGS + i for i < NUM_PREGS - NUM_AREGS. head_ptr = 0. tail_ptr = 96. free_count = 96. empty = 0. alloc_pd = 32. alloc_valid = 1. All checkpoint slots = 0. Reset mid-operation discards all in-flight state and checkpoints.
- Allocate: a grant occurs when alloc_req && !empty && !recover_en.
  - alloc_pd is the entry at head_ptr, valid in the same cycle (zero latency).
  - head_ptr advances by 1 at the clock edge.
  - When empty, alloc_valid = 0, head_ptr holds, and the request is dropped. Rename must stall.
- Release: when release_en && release_pd != 0, write release_pd at tail_ptr and advance tail_ptr by 1. release_pd == 0 is ignored.
  - Release is accepted in every cycle, including a recover cycle. Commit is never speculative.
  - Overflow cannot occur by construction, because free tags plus speculatively allocated tags never exceed NUM_PREGS - NUM_AREGS.
- Checkpoint save: slot[ckpt_save_id] is written with the head_ptr value after this cycle's grant, if any. A branch renamed in the same cycle as an allocation therefore keeps that allocation. A save to a slot overwrites it.
- Recover:
  - head_ptr = slot[recover_id] at the edge.
  - Every tag allocated after that save becomes free again. The buffer entries are untouched, so no rewrite is needed.
  - An alloc_req in the same cycle is not granted: alloc_valid is forced to 0 while recover_en is high.
  - A ckpt_save_en in the same cycle is ignored.
  - free_count reflects the restored head_ptr plus any same-cycle release on the next cycle.
- Simultaneous grant and release: head_ptr and tail_ptr both advance, so free_count is unchanged. Releasing into the last free slot while empty makes alloc_valid high on the next cycle, not the same cycle (no bypass).
- Wrap-around: the pointers wrap modulo 2^(TAG_W+1). The buffer index is ptr[TAG_W-1:0].
- free_count and empty are updated at the clock edge, consistent with the next-cycle pointers.

Decomposition:
- Shared package (the existing core package): NUM_PREGS, NUM_AREGS, NUM_CKPT, TAG_W, CKPT_W, a preg_tag_t typedef of TAG_W bits, and a fl_ptr_t typedef of TAG_W+1 bits.
- One natural sub-module, fl_ckpt_table: NUM_CKPT x fl_ptr_t registers with one write port and one read port. The top level holds the buffer, the pointers and the priority logic.

Test Plan:
1. Reset, then alloc_req held for 3 cycles -> alloc_pd = 32, 33, 34 with alloc_valid = 1; free_count 96 -> 93.
2. 96 consecutive allocs -> last tag 127; empty = 1; the 97th alloc_req gives alloc_valid = 0 and head_ptr unchanged. Next, release_pd = 40 -> one cycle later alloc_valid = 1 and alloc_pd = 40.
3. Alloc and release (release_pd = 7) in the same cycle, from free_count = 50 -> free_count stays 50. Later, after the pool drains to tag 7, alloc_pd = 7.
4. After reset, alloc 32 and 33, save slot 2, alloc 34 and 35, then recover_en with recover_id = 2 -> next alloc_pd = 34; free_count = 94.
5. recover_en, alloc_req and release_en (pd = 9) in the same cycle -> no grant; head_ptr restored; tail_ptr advances; tag 9 appears after the restored pool contents.
6. release_pd = 0 -> free_count unchanged. Assert reset mid-sequence -> alloc_pd = 32 and free_count = 96 on the next cycle.

Source files
------------

// File: rtl/phys_reg_free_list_pkg.sv
// phys_reg_free_list_pkg
//   Shared core constants and types for the physical register free list.
//   NUM_PREGS physical tags, NUM_AREGS of which hold the reset-time
//   architectural mapping and are never in the initial pool.
package phys_reg_free_list_pkg;

  localparam int NUM_PREGS = 128;
  localparam int NUM_AREGS = 32;
  localparam int NUM_CKPT  = 4;
  localparam int TAG_W     = $clog2(NUM_PREGS);
  localparam int CKPT_W    = $clog2(NUM_CKPT);
  localparam int INIT_FREE = NUM_PREGS - NUM_AREGS;

  typedef logic [TAG_W-1:0] preg_tag_t;
  // One extra MSB acts as the wrap bit so full and empty are distinguishable.
  typedef logic [TAG_W:0]   fl_ptr_t;

endpackage

// File: rtl/phys_reg_free_list_ckpt_table.sv
// fl_ckpt_table
//   NUM_CKPT slots of saved free-list head pointers.
//   Ports:
//     clk, reset     clock and synchronous active-high reset (clears slots)
//     we/waddr/wdata write port, applied at the clock edge
//     raddr/rdata    combinational read port
module fl_ckpt_table
  import phys_reg_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [CKPT_W-1:0] waddr,
  input  fl_ptr_t           wdata,
  input  logic [CKPT_W-1:0] raddr,
  output fl_ptr_t           rdata
);

  fl_ptr_t slot_q [NUM_CKPT];
  fl_ptr_t slot_d [NUM_CKPT];

  always_comb begin
    for (int i = 0; i < NUM_CKPT; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (we) begin
      slot_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  assign rdata = slot_q[raddr];

endmodule

// File: rtl/phys_reg_free_list.sv
// phys_reg_free_list
//   Circular-buffer allocator for physical register tags, with branch
//   checkpoints of the head pointer for single-cycle mispredict recovery.
//   Ports:
//     clk, reset               clock, synchronous active-high reset
//     alloc_req                rename wants one tag this cycle
//     alloc_valid, alloc_pd    combinational head-of-pool tag and its valid
//     release_en, release_pd   commit frees a tag (tag 0 is ignored)
//     ckpt_save_en/_id         snapshot the post-grant head pointer
//     recover_en/_id           restore head pointer from a snapshot
//     free_count, empty        registered pool occupancy
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [TAG_W-1:0]  alloc_pd,
  input  logic              release_en,
  input  logic [TAG_W-1:0]  release_pd,
  input  logic              ckpt_save_en,
  input  logic [CKPT_W-1:0] ckpt_save_id,
  input  logic              recover_en,
  input  logic [CKPT_W-1:0] recover_id,
  output logic [TAG_W:0]    free_count,
  output logic              empty
);

  preg_tag_t buf_q [NUM_PREGS];

  fl_ptr_t head_q, head_d;
  fl_ptr_t tail_q, tail_d;
  fl_ptr_t free_count_q, free_count_d;
  fl_ptr_t head_post_grant;
  fl_ptr_t ckpt_rdata;
  logic    grant;
  logic    rel_fire;
  logic    ckpt_we;

  assign empty       = (free_count_q == '0);
  assign free_count  = free_count_q;
  // A recover cycle never grants, so rename sees no tag that cycle.
  assign alloc_valid = !empty && !recover_en;
  assign alloc_pd    = buf_q[head_q[TAG_W-1:0]];

  always_comb begin
    grant           = alloc_req && !empty && !recover_en;
    rel_fire        = release_en && (release_pd != '0);
    head_post_grant = head_q + fl_ptr_t'(grant);
    // Recovery only rewinds the head; entries behind the old head are
    // still intact in the buffer, so squashed tags are free again at once.
    head_d          = recover_en ? ckpt_rdata : head_post_grant;
    tail_d          = tail_q + fl_ptr_t'(rel_fire);
    free_count_d    = tail_d - head_d;
    // A branch renamed alongside an allocation keeps that allocation.
    ckpt_we         = ckpt_save_en && !recover_en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= fl_ptr_t'(INIT_FREE);
      free_count_q <= fl_ptr_t'(INIT_FREE);
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      free_count_q <= free_count_d;
    end
  end

  // Entries past the initial pool are don't-care until released into.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PREGS; i++) begin
        buf_q[i] <= (i < INIT_FREE) ? preg_tag_t'(NUM_AREGS + i) : '0;
      end
    end else if (rel_fire) begin
      buf_q[tail_q[TAG_W-1:0]] <= release_pd;
    end
  end

  fl_ckpt_table u_ckpt (
    .clk   (clk),
    .reset (reset),
    .we    (ckpt_we),
    .waddr (ckpt_save_id),
    .wdata (head_post_grant),
    .raddr (recover_id),
    .rdata (ckpt_rdata)
  );

endmodule

// File: tb/tb_phys_reg_free_list.sv
// tb_phys_reg_free_list
//   Bench for phys_reg_free_list. The reference keeps an ordered log of
//   every tag that ever entered the pool plus an allocation index; the free
//   pool is the log from that index onward, and checkpoints save the index.
module tb_phys_reg_free_list;
  import phys_reg_free_list_pkg::*;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              alloc_req = 1'b0;
  logic              alloc_valid;
  logic [TAG_W-1:0]  alloc_pd;
  logic              release_en = 1'b0;
  logic [TAG_W-1:0]  release_pd = '0;
  logic              ckpt_save_en = 1'b0;
  logic [CKPT_W-1:0] ckpt_save_id = '0;
  logic              recover_en = 1'b0;
  logic [CKPT_W-1:0] recover_id = '0;
  logic [TAG_W:0]    free_count;
  logic              empty;

  always #5 clk = ~clk;

  phys_reg_free_list dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_valid  (alloc_valid),
    .alloc_pd     (alloc_pd),
    .release_en   (release_en),
    .release_pd   (release_pd),
    .ckpt_save_en (ckpt_save_en),
    .ckpt_save_id (ckpt_save_id),
    .recover_en   (recover_en),
    .recover_id   (recover_id),
    .free_count   (free_count),
    .empty        (empty)
  );

  int n_vec = 0;
  int n_bad = 0;

  int log_q[$];
  int head_m;
  int ck_m  [NUM_CKPT];
  bit ck_ok [NUM_CKPT];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_free();
    return log_q.size() - head_m;
  endfunction

  task automatic model_reset();
    log_q.delete();
    for (int i = 0; i < NUM_PREGS - NUM_AREGS; i++) log_q.push_back(NUM_AREGS + i);
    head_m = 0;
    for (int k = 0; k < NUM_CKPT; k++) begin
      ck_m[k]  = 0;
      ck_ok[k] = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    alloc_req = 0; release_en = 0; release_pd = '0;
    ckpt_save_en = 0; recover_en = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // One cycle: drive, check outputs mid-cycle against the model, then
  // advance the model at the clock edge.
  task automatic step(input bit req, input bit rel, input int rpd,
                      input bit sv, input int sid, input bit rec, input int rid,
                      input string tag);
    int  fr;
    bit  gnt;
    int  post;
    alloc_req    = req;
    release_en   = rel;
    release_pd   = rpd[TAG_W-1:0];
    ckpt_save_en = sv;
    ckpt_save_id = sid[CKPT_W-1:0];
    recover_en   = rec;
    recover_id   = rid[CKPT_W-1:0];
    @(negedge clk);
    fr = m_free();
    check({tag, ":cnt"},   free_count,  fr);
    check({tag, ":empty"}, empty,       (fr == 0));
    check({tag, ":valid"}, alloc_valid, (fr > 0) && !rec);
    if (fr > 0) check({tag, ":pd"}, alloc_pd, log_q[head_m]);
    @(posedge clk);
    gnt  = req && (fr > 0) && !rec;
    post = head_m + (gnt ? 1 : 0);
    head_m = rec ? ck_m[rid] : post;
    if (rel && rpd != 0) log_q.push_back(rpd);
    if (sv && !rec) begin
      ck_m[sid]  = post;
      ck_ok[sid] = 1'b1;
    end
    // A snapshot is only trustworthy while its entries cannot be overwritten.
    for (int k = 0; k < NUM_CKPT; k++)
      if (log_q.size() - ck_m[k] > NUM_PREGS) ck_ok[k] = 1'b0;
    #1;
  endtask

  initial begin
    int ap;
    bit rq, rl, sv, rc;
    int rp, sd, rd, base;

    model_reset();
    do_reset();
    @(negedge clk);
    check("rst_pd",    alloc_pd,    32);
    check("rst_cnt",   free_count,  96);
    check("rst_valid", alloc_valid, 1);
    check("rst_empty", empty,       0);
    @(posedge clk); #1;

    // 1: three allocations
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, "t1_alloc");
    check("t1_cnt", free_count, 93);

    // 2: drain, overflow request, release 40
    for (int i = 0; i < 93; i++) step(1, 0, 0, 0, 0, 0, 0, "t2_drain");
    check("t2_empty", empty, 1);
    step(1, 0, 0, 0, 0, 0, 0, "t2_97th");
    step(0, 1, 40, 0, 0, 0, 0, "t2_rel40");
    check("t2_valid40", alloc_valid, 1);
    check("t2_pd40",    alloc_pd,    40);
    step(1, 0, 0, 0, 0, 0, 0, "t2_alloc40");

    // 3: alloc + release in same cycle at free_count 50
    do_reset();
    for (int i = 0; i < 46; i++) step(1, 0, 0, 0, 0, 0, 0, "t3_fill");
    check("t3_cnt50", free_count, 50);
    step(1, 1, 7, 0, 0, 0, 0, "t3_both");
    check("t3_cnt_kept", free_count, 50);
    for (int i = 0; i < 49; i++) step(1, 0, 0, 0, 0, 0, 0, "t3_drain");
    check("t3_pd7", alloc_pd, 7);

    // 4: checkpoint and recover
    do_reset();
    step(1, 0, 0, 0, 0, 0, 0, "t4_a32");
    step(1, 0, 0, 0, 0, 0, 0, "t4_a33");
    step(0, 0, 0, 1, 2, 0, 0, "t4_save");
    step(1, 0, 0, 0, 0, 0, 0, "t4_a34");
    step(1, 0, 0, 0, 0, 0, 0, "t4_a35");
    step(0, 0, 0, 0, 0, 1, 2, "t4_rec");
    check("t4_pd34", alloc_pd,   34);
    check("t4_cnt",  free_count, 94);

    // 5: recover with same-cycle alloc, release and ignored save
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, "t5_alloc");
    step(1, 1, 9, 1, 3, 1, 2, "t5_rec_rel");
    check("t5_pd34", alloc_pd,   34);
    check("t5_cnt",  free_count, 95);
    for (int i = 0; i < 94; i++) step(1, 0, 0, 0, 0, 0, 0, "t5_drain");
    check("t5_pd9", alloc_pd, 9);

    // 6: release of tag 0, then reset mid-sequence
    step(0, 1, 0, 0, 0, 0, 0, "t6_rel0");
    check("t6_cnt", free_count, 1);
    step(1, 1, 11, 0, 0, 0, 0, "t6_busy");
    do_reset();
    @(negedge clk);
    check("t6_rst_pd",  alloc_pd,   32);
    check("t6_rst_cnt", free_count, 96);
    @(posedge clk); #1;

    // Randomized traffic with phases of heavy and light allocation.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      ap = ((c / 250) % 2 == 0) ? 80 : 25;
      rq = ($urandom_range(0, 99) < ap);
      rc = ($urandom_range(0, 15) == 0);
      rd = $urandom_range(0, NUM_CKPT - 1);
      if (rc && !ck_ok[rd]) rc = 0;
      sv = ($urandom_range(0, 7) == 0);
      sd = $urandom_range(0, NUM_CKPT - 1);
      rl = ($urandom_range(0, 99) < 50);
      rp = $urandom_range(0, NUM_PREGS - 1);
      base = rc ? ck_m[rd] : head_m;
      if (rl && (log_q.size() + 1 - base > NUM_PREGS)) rl = 0;
      step(rq, rl, rp, sv, sd, rc, rd, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
